// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline writeback request, long-latency result
// handshake, and the registered register-file write port.
interface wb_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lat_valid;
  logic [4:0]  lat_rd;
  logic [31:0] lat_data;
  logic        lat_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_src;

  // arbiter side
  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, lat_valid, lat_rd, lat_data,
    output lat_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, rf_src
  );

  // requester / register-file side
  modport master (
    output pipe_valid, pipe_rd, pipe_data, lat_valid, lat_rd, lat_data,
    input  lat_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, rf_src
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single scalar register-file write port between
// MEM/WB writeback and a 2-entry in-order FIFO of long-latency results.
// The pipeline normally wins; a buffered result is forced through when the
// FIFO is full or after it has lost STARVE_LIMIT cycles in a row.
// Optional feature: define WB_ARB_BYPASS_EN to let an accepted result skip
// the empty FIFO and write on the next edge when the pipeline is idle.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4  // legal 1..15
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  ent_t [1:0]  fifo_q, fifo_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [3:0]  starve_q, starve_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        rf_src_q, rf_src_d;

  logic pipe_eff, lat_ready, grant_fifo, accept, bypass, push, pop, pipe_win;
  ent_t head;

  assign head = fifo_q[rd_ptr_q];

  // Arbitration, FIFO bookkeeping and next write-port contents.
  always_comb begin
    // rd==0 writes are no-ops everywhere: never write, stall or buffer them
    pipe_eff   = bus.pipe_valid && (bus.pipe_rd != 5'd0);
    lat_ready  = (count_q < 2'd2);
    grant_fifo = (count_q == 2'd2) || (starve_q == LIMIT);
    accept     = bus.lat_valid && lat_ready && (bus.lat_rd != 5'd0);
`ifdef WB_ARB_BYPASS_EN
    bypass     = accept && (count_q == 2'd0) && !pipe_eff;
`else
    bypass     = 1'b0;
`endif
    push       = accept && !bypass;
    pop        = 1'b0;
    pipe_win   = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = 5'd0;
    rf_wdata_d = 32'd0;
    rf_src_d   = 1'b0;

    // starve_q only reaches LIMIT while the FIFO holds something, so a
    // grant always has a head entry to pop
    if (grant_fifo) begin
      pop        = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
      rf_src_d   = 1'b1;
    end else if (pipe_eff) begin
      pipe_win   = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.pipe_rd;
      rf_wdata_d = bus.pipe_data;
    end else if (count_q != 2'd0) begin
      pop        = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
      rf_src_d   = 1'b1;
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.lat_rd;
      rf_wdata_d = bus.lat_data;
      rf_src_d   = 1'b1;
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{rd: bus.lat_rd, data: bus.lat_data};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    // push+pop together leaves the occupancy unchanged
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;

    starve_d = starve_q;
    if (pop || (count_q == 2'd0))          starve_d = 4'd0;
    else if (pipe_win && starve_q != LIMIT) starve_d = starve_q + 4'd1;
  end

  // State registers; reset drops any buffered results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      starve_q   <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      rf_src_q   <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_src_q   <= rf_src_d;
    end
  end

  assign bus.lat_ready  = lat_ready;
  assign bus.stall_pipe = pipe_eff && grant_fifo;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_src     = rf_src_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, scored
// against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;
  localparam int LIM = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; logic src; } exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  wb_arbiter_if bus();
  wb_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];   // expected rf writes, oldest first
  ent_t mq[$];      // model of buffered long-latency results
  int   starve = 0; // model: consecutive cycles the buffered head lost
  bit   last_stall = 1'b0;
  bit   last_lat_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: decide this cycle's write from the rules and queue it.
  task automatic model_step();
    bit pe, lr, grant, acc, byp, popped, pwin, nonempty;
    ent_t e;
    exp_t x;
    pe       = bus.pipe_valid && (bus.pipe_rd != 5'd0);
    nonempty = (mq.size() != 0);
    lr       = (mq.size() < 2);
    grant    = (mq.size() == 2) || (starve == LIM);
    chk("lat_ready", {31'd0, bus.lat_ready}, {31'd0, lr});
    chk("stall_pipe", {31'd0, bus.stall_pipe}, {31'd0, pe && grant});
    acc    = bus.lat_valid && lr && (bus.lat_rd != 5'd0);
    byp    = BYP && acc && !nonempty && !pe;
    popped = 1'b0;
    pwin   = 1'b0;
    x.cyc  = cyc + 1;
    if (grant && nonempty) begin
      e = mq.pop_front(); popped = 1'b1;
      x.rd = e.rd; x.data = e.data; x.src = 1'b1; exp_q.push_back(x);
    end else if (pe) begin
      pwin = 1'b1;
      x.rd = bus.pipe_rd; x.data = bus.pipe_data; x.src = 1'b0; exp_q.push_back(x);
    end else if (nonempty) begin
      e = mq.pop_front(); popped = 1'b1;
      x.rd = e.rd; x.data = e.data; x.src = 1'b1; exp_q.push_back(x);
    end else if (byp) begin
      x.rd = bus.lat_rd; x.data = bus.lat_data; x.src = 1'b1; exp_q.push_back(x);
    end
    if (acc && !byp) begin
      e.rd = bus.lat_rd; e.data = bus.lat_data; mq.push_back(e);
    end
    if (popped || !nonempty) starve = 0;
    else if (pwin && starve < LIM) starve++;
    last_stall    = pe && grant;
    last_lat_hold = bus.lat_valid && !lr;
  endtask

  task automatic drive(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk); #1;
    bus.pipe_valid = pv; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.lat_valid  = lv; bus.lat_rd  = lrd; bus.lat_data  = ld;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete(); mq.delete(); starve = 0;
    last_stall = 1'b0; last_lat_hold = 1'b0;
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h5;
    bus.lat_valid  = 1'b1; bus.lat_rd  = 5'd4; bus.lat_data  = 32'h6;
    @(negedge clk);
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_rf_src", {31'd0, bus.rf_src}, 32'd0);
    chk("rst_lat_ready", {31'd0, bus.lat_ready}, 32'd1);
    chk("rst_stall", {31'd0, bus.stall_pipe}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.pipe_valid = 1'b0; bus.lat_valid = 1'b0;
  endtask

  // Monitor: every DUT write must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t x;
    if (!reset && bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_write: got waddr=%0d wdata=%0h, want no write (cycle %0d)",
                 bus.rf_waddr, bus.rf_wdata, cyc);
      end else begin
        x = exp_q.pop_front();
        chk("wr_cycle", cyc, x.cyc);
        chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, x.rd});
        chk("rf_wdata", bus.rf_wdata, x.data);
        chk("rf_src", {31'd0, bus.rf_src}, {31'd0, x.src});
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      total++; bad++;
      $display("FAIL missed_write: got rf_we=%0b, want write rd=%0d (cycle %0d)",
               bus.rf_we, exp_q[0].rd, cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    bit pv, lv;
    logic [4:0] prd, lrd;
    logic [31:0] pd, ld;
    bus.pipe_valid = 1'b0; bus.pipe_rd = 5'd0; bus.pipe_data = 32'd0;
    bus.lat_valid  = 1'b0; bus.lat_rd  = 5'd0; bus.lat_data  = 32'd0;
    do_reset();

    // pipe only
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(2);
    // lone long-latency result, pipeline idle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    idle(3);
    // pipeline busy, one result: starvation forces it through
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 9; i++) drive(1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'd0);
    idle(2);
    // two results while pipeline busy: FIFO fills, pipe stalls
    drive(1'b1, 5'd3, 32'hB3, 1'b1, 5'd10, 32'h1010);
    drive(1'b1, 5'd3, 32'hB3, 1'b1, 5'd11, 32'h1111);
    for (int i = 0; i < 6; i++) drive(1'b1, 5'd3, 32'hB3, 1'b0, 5'd0, 32'd0);
    idle(3);
    // rd==0 on both sides is idle
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
    idle(2);
    // reset with FIFO full, then nothing buffered may emerge
    drive(1'b1, 5'd3, 32'hC3, 1'b1, 5'd12, 32'h1212);
    drive(1'b1, 5'd3, 32'hC3, 1'b1, 5'd13, 32'h1313);
    do_reset();
    idle(4);

    // random traffic with MEM/WB hold on stall and valid hold on backpressure
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (last_stall) begin
        pv = bus.pipe_valid; prd = bus.pipe_rd; pd = bus.pipe_data;
      end else begin
        pv  = ($urandom_range(0, 99) < 70);
        prd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pd  = $urandom;
      end
      if (last_lat_hold) begin
        lv = bus.lat_valid; lrd = bus.lat_rd; ld = bus.lat_data;
      end else begin
        lv  = ($urandom_range(0, 99) < 35);
        lrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld  = $urandom;
      end
      drive(pv, prd, pd, lv, lrd, ld);
    end
    idle(6);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
